pll_sequencer: RTL
==================

PLL_SEQUENCER -- requirements
Module: pll_sequencer

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 16: cycles pll_resetb is held low per attempt (1..65535).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 1200: cycles allowed in WAIT for lock (1..65535).
REQ-003 SHALL have parameter STABLE_CYCLES, default 256: consecutive locked cycles required before ready (1..65535).
REQ-004 SHALL have parameter MAX_RETRIES, default 3: failed attempts before FAULT (1..15).
REQ-005 SHALL have ports: clk in 1, board oscillator, sole clock.
REQ-006 rst in 1: reset, synchronous, active-high.
REQ-007 lock_raw in 1: PLL LOCK, asynchronous to clk.
REQ-008 restart in 1: one-cycle request to leave FAULT.
REQ-009 pll_resetb out 1: drives PLL RESETB, active-low.
REQ-010 ready out 1: PLL locked and stable; downstream may leave reset.
REQ-011 fault out 1: retries exhausted.
REQ-012 lock_lost out 1: one-cycle pulse on lock loss in RUN.
REQ-013 state out 3: HOLD=0, WAIT=1, SETTLE=2, RUN=3, FAULT=4.
REQ-014 retry_cnt out 4: failed attempts since last success or restart.
REQ-015 loss_cnt out 8: lock-loss event count (see Configuration).

Function
REQ-016 SHALL synchronise lock_raw through two clk flops to lock_s; all decisions use lock_s only.
REQ-017 SHALL use one 16-bit cycle counter, cleared on every state change.
REQ-018 HOLD: pll_resetb=0; at counter==HOLD_CYCLES-1 -> WAIT.
REQ-019 WAIT: pll_resetb=1; lock_s=1 -> SETTLE; else at counter==LOCK_TIMEOUT-1: retry_cnt+1, then FAULT if the new value equals MAX_RETRIES, else HOLD.
REQ-020 WAIT, lock_s=1 in the timeout cycle: lock wins -> SETTLE, no retry increment.
REQ-021 SETTLE: pll_resetb=1; counter increments while lock_s=1; lock_s=0 -> HOLD, retry_cnt unchanged; at counter==STABLE_CYCLES-1 with lock_s=1 -> RUN, retry_cnt cleared.
REQ-022 RUN: pll_resetb=1, ready=1; lock_s=0 -> HOLD with lock_lost=1 for exactly one cycle.
REQ-023 FAULT: pll_resetb=0, fault=1; restart=1 -> HOLD, retry_cnt cleared; restart ignored in all other states.
REQ-024 All outputs SHALL be registered; ready, fault, pll_resetb and state update on the same edge as the state transition.
REQ-025 Lock-loss latency: ready SHALL fall on the 3rd clk edge after lock_raw falls (2 sync + 1 register).

Reset
REQ-026 rst=1 SHALL force next edge: state=HOLD, counter=0, retry_cnt=0, sync flops=0, pll_resetb=0, ready=0, fault=0, lock_lost=0, loss_cnt=0.
REQ-027 rst asserted mid-operation (any state) SHALL abort immediately with no lock_lost pulse; the sequence restarts from HOLD.

Configuration
REQ-028 Macro PLL_SEQ_LOSS_CNT_EN defined: loss_cnt increments on each lock_lost pulse, saturating at 255, cleared only by rst.
REQ-029 Macro undefined: loss_cnt is constant 0 and its counter logic is not built; all other behaviour is identical.

Verification (HOLD_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2)
REQ-030 lock_raw rises 5 cycles after pll_resetb rises and stays high -> ready=1 and state=3 after the 11th clk edge following the lock_raw rise; retry_cnt=0.
REQ-031 lock_raw held 0 -> two HOLD(4)/WAIT(20) attempts, then state=4, fault=1, pll_resetb=0, retry_cnt=2; remains there indefinitely.
REQ-032 In FAULT, restart pulsed 1 cycle -> next edge state=0, fault=0, retry_cnt=0; pll_resetb rises 4 cycles later.
REQ-033 In RUN, lock_raw low 1 cycle -> ready=0 and lock_lost=1 for one cycle, state=0; loss_cnt=1 with PLL_SEQ_LOSS_CNT_EN, 0 without; relocks to RUN.
REQ-034 In SETTLE, lock_raw glitches low at counter=5 -> state=0, retry_cnt unchanged, ready never asserted.
REQ-035 rst asserted 1 cycle while in WAIT at counter=10 -> all outputs at reset values, lock_lost=0, sequence restarts with a full 4-cycle HOLD.

Source files
------------

// File: rtl/pll_sequencer.sv
// PLL reset/lock sequencer: holds the PLL in reset, waits for lock, demands a stable
// lock window before raising ready, and retries up to a limit. Optional loss counter: PLL_SEQ_LOSS_CNT_EN.
module pll_sequencer #(
    parameter int HOLD_CYCLES   = 16,
    parameter int LOCK_TIMEOUT  = 1200,
    parameter int STABLE_CYCLES = 256,
    parameter int MAX_RETRIES   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lock_raw,
    input  logic       restart,
    output logic       pll_resetb,
    output logic       ready,
    output logic       fault,
    output logic       lock_lost,
    output logic [2:0] state,
    output logic [3:0] retry_cnt,
    output logic [7:0] loss_cnt
);

    typedef enum logic [2:0] {
        ST_HOLD   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_FAULT  = 3'd4
    } state_t;

    localparam logic [15:0] HOLD_LAST    = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
    localparam logic [15:0] STABLE_LAST  = 16'(STABLE_CYCLES - 1);
    localparam logic [3:0]  RETRY_LIMIT  = 4'(MAX_RETRIES);

    state_t      state_r;
    state_t      state_nx_s;
    logic [15:0] cnt_r;
    logic [15:0] cnt_nx_s;
    logic [3:0]  retry_r;
    logic [3:0]  retry_nx_s;
    logic [3:0]  retry_inc_s;
    logic        lock_meta_r;
    logic        lock_s_r;
    logic        lost_evt_s;
    logic        pll_resetb_r;
    logic        ready_r;
    logic        fault_r;
    logic        lock_lost_r;

    // Two-flop synchroniser for the asynchronous PLL lock indication
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_meta_r <= 1'b0;
            lock_s_r    <= 1'b0;
        end else begin
            lock_meta_r <= lock_raw;
            lock_s_r    <= lock_meta_r;
        end
    end

    // Next-state, cycle counter and retry bookkeeping
    always_comb begin
        state_nx_s  = state_r;
        cnt_nx_s    = cnt_r;
        retry_nx_s  = retry_r;
        retry_inc_s = retry_r + 4'd1;
        lost_evt_s  = 1'b0;
        case (state_r)
            ST_HOLD: begin
                if (cnt_r == HOLD_LAST) begin
                    state_nx_s = ST_WAIT;
                    cnt_nx_s   = 16'd0;
                end else begin
                    cnt_nx_s = cnt_r + 16'd1;
                end
            end
            ST_WAIT: begin
                // Lock seen in the timeout cycle still wins over the retry
                if (lock_s_r) begin
                    state_nx_s = ST_SETTLE;
                    cnt_nx_s   = 16'd0;
                end else if (cnt_r == TIMEOUT_LAST) begin
                    retry_nx_s = retry_inc_s;
                    state_nx_s = (retry_inc_s == RETRY_LIMIT) ? ST_FAULT : ST_HOLD;
                    cnt_nx_s   = 16'd0;
                end else begin
                    cnt_nx_s = cnt_r + 16'd1;
                end
            end
            ST_SETTLE: begin
                if (!lock_s_r) begin
                    state_nx_s = ST_HOLD;
                    cnt_nx_s   = 16'd0;
                end else if (cnt_r == STABLE_LAST) begin
                    state_nx_s = ST_RUN;
                    cnt_nx_s   = 16'd0;
                    retry_nx_s = 4'd0;
                end else begin
                    cnt_nx_s = cnt_r + 16'd1;
                end
            end
            ST_RUN: begin
                if (!lock_s_r) begin
                    state_nx_s = ST_HOLD;
                    cnt_nx_s   = 16'd0;
                    lost_evt_s = 1'b1;
                end else begin
                    cnt_nx_s = cnt_r;
                end
            end
            ST_FAULT: begin
                if (restart) begin
                    state_nx_s = ST_HOLD;
                    cnt_nx_s   = 16'd0;
                    retry_nx_s = 4'd0;
                end else begin
                    cnt_nx_s = cnt_r;
                end
            end
            default: begin
                state_nx_s = ST_HOLD;
                cnt_nx_s   = 16'd0;
            end
        endcase
    end

    // State register; outputs are decoded from the next state so they move with it
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_HOLD;
            cnt_r        <= 16'd0;
            retry_r      <= 4'd0;
            pll_resetb_r <= 1'b0;
            ready_r      <= 1'b0;
            fault_r      <= 1'b0;
            lock_lost_r  <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            cnt_r        <= cnt_nx_s;
            retry_r      <= retry_nx_s;
            pll_resetb_r <= (state_nx_s == ST_WAIT) || (state_nx_s == ST_SETTLE) ||
                            (state_nx_s == ST_RUN);
            ready_r      <= (state_nx_s == ST_RUN);
            fault_r      <= (state_nx_s == ST_FAULT);
            lock_lost_r  <= lost_evt_s;
        end
    end

`ifdef PLL_SEQ_LOSS_CNT_EN
    logic [7:0] loss_cnt_r;

    // Saturating lock-loss event counter, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            loss_cnt_r <= 8'd0;
        end else if (lost_evt_s && (loss_cnt_r != 8'hFF)) begin
            loss_cnt_r <= loss_cnt_r + 8'd1;
        end else begin
            loss_cnt_r <= loss_cnt_r;
        end
    end

    assign loss_cnt = loss_cnt_r;
`else
    assign loss_cnt = 8'd0;
`endif

    assign pll_resetb = pll_resetb_r;
    assign ready      = ready_r;
    assign fault      = fault_r;
    assign lock_lost  = lock_lost_r;
    assign state      = state_r;
    assign retry_cnt  = retry_r;

endmodule
